// File: rtl/result_matrix_collector_pkg.sv
// Shared definitions for the result matrix collector and its neighbours.
// Purpose: FSM state encodings, default widths and a small clog2 helper
//          used to size the internal row/column index registers.
// Ports:   none (package).
package result_matrix_collector_pkg;

  localparam int DW_DEFAULT = 32;
  localparam int IW_DEFAULT = 5;

  typedef enum logic {
    S_COLLECT = 1'b0,
    S_DRAIN   = 1'b1
  } state_t;

  // Ceiling log2, evaluated at elaboration time for parameter sizing.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Index register width; a 1x1 matrix still needs a 1-bit index.
  function automatic int idx_width(input int m);
    return (m <= 1) ? 1 : clog2(m);
  endfunction

endpackage

// File: rtl/result_matrix_collector_if.sv
// Bundle of the result-input handshake, the done pulse, the output
// stream and the status flags of the result matrix collector.
// Purpose: lets the collector and its neighbours connect with one port.
// Ports (slave = collector side):
//   in : z_in, z_i, z_j, z_stb, done_in, out_ready
//   out: z_ack, out_data, out_row, out_col, out_valid, out_last,
//        busy, err_range, err_miss
interface result_matrix_collector_if
  import result_matrix_collector_pkg::*;
#(
  parameter int IW = IW_DEFAULT,
  parameter int DW = DW_DEFAULT
) ();

  logic [DW-1:0] z_in;
  logic [IW-1:0] z_i;
  logic [IW-1:0] z_j;
  logic          z_stb;
  logic          z_ack;
  logic          done_in;
  logic [DW-1:0] out_data;
  logic [IW-1:0] out_row;
  logic [IW-1:0] out_col;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          busy;
  logic          err_range;
  logic          err_miss;

  modport slave (
    input  z_in, z_i, z_j, z_stb, done_in, out_ready,
    output z_ack, out_data, out_row, out_col, out_valid, out_last,
           busy, err_range, err_miss
  );

  modport master (
    output z_in, z_i, z_j, z_stb, done_in, out_ready,
    input  z_ack, out_data, out_row, out_col, out_valid, out_last,
           busy, err_range, err_miss
  );

endinterface

// File: rtl/result_matrix_collector_regfile.sv
// M x M register file holding the result matrix.
// Purpose: one synchronous write port and one combinational read port.
// Ports:
//   clk          rising-edge clock
//   we           write enable
//   wr_i, wr_j   write row / column
//   wd           write data
//   rd_i, rd_j   read row / column
//   rd_data      read data (combinational)
// Contents are not reset; every entry is rewritten before it matters.
module result_regfile #(
  parameter int M    = 4,
  parameter int DW   = 32,
  parameter int IDXW = 2
) (
  input  logic            clk,
  input  logic            we,
  input  logic [IDXW-1:0] wr_i,
  input  logic [IDXW-1:0] wr_j,
  input  logic [DW-1:0]   wd,
  input  logic [IDXW-1:0] rd_i,
  input  logic [IDXW-1:0] rd_j,
  output logic [DW-1:0]   rd_data
);

  logic [DW-1:0] mem [M][M];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_i][wr_j] <= wd;
    end
  end

  assign rd_data = mem[rd_i][rd_j];

endmodule

// File: rtl/result_matrix_collector.sv
// Downstream stage of the sequential matrix multiplier.
// Purpose: collects (z_i, z_j, z_in) results into an M x M buffer (later
//          writes replace earlier ones), then on done_in streams the whole
//          matrix row-major over a valid/ready port.
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-low reset
//   bus   result_matrix_collector_if.slave: result handshake (z_*),
//         done_in, output stream (out_*), busy, sticky err_range/err_miss
module result_matrix_collector
  import result_matrix_collector_pkg::*;
#(
  parameter int M  = 4,
  parameter int IW = IW_DEFAULT,
  parameter int DW = DW_DEFAULT
) (
  input  logic                        clk,
  input  logic                        rst,
  result_matrix_collector_if.slave    bus
);

  localparam int              IDXW     = idx_width(M);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(M - 1);

  state_t                    state, state_n;
  logic                      z_ack_q, z_ack_n;
  logic [IDXW-1:0]           rd_row, rd_row_n;
  logic [IDXW-1:0]           rd_col, rd_col_n;
  logic [M-1:0][M-1:0]       written, written_n;
  logic                      err_range_q, err_range_n;
  logic                      err_miss_q, err_miss_n;
  logic                      we;
  logic                      in_range;
  logic                      drain_active;
  logic [IDXW-1:0]           wr_row, wr_col;
  logic [DW-1:0]             rd_data;

  // Range test uses the full port width so that high index bits are never
  // silently dropped into an aliased in-range write.
  assign in_range = (32'(bus.z_i) < M) && (32'(bus.z_j) < M);
  assign wr_row   = bus.z_i[IDXW-1:0];
  assign wr_col   = bus.z_j[IDXW-1:0];

  result_regfile #(
    .M    (M),
    .DW   (DW),
    .IDXW (IDXW)
  ) u_regfile (
    .clk     (clk),
    .we      (we),
    .wr_i    (wr_row),
    .wr_j    (wr_col),
    .wd      (bus.z_in),
    .rd_i    (rd_row),
    .rd_j    (rd_col),
    .rd_data (rd_data)
  );

  // State, handshake, read index, bitmap and sticky error registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_COLLECT;
      z_ack_q     <= 1'b0;
      rd_row      <= '0;
      rd_col      <= '0;
      written     <= '0;
      err_range_q <= 1'b0;
      err_miss_q  <= 1'b0;
    end else begin
      state       <= state_n;
      z_ack_q     <= z_ack_n;
      rd_row      <= rd_row_n;
      rd_col      <= rd_col_n;
      written     <= written_n;
      err_range_q <= err_range_n;
      err_miss_q  <= err_miss_n;
    end
  end

  // Next-state logic. z_ack defaults low so it is a one-cycle pulse and the
  // strobe still high during the ack cycle is not taken as a new result.
  // A write accepted alongside done_in is folded into written_n before the
  // completeness check, so it counts as written.
  always_comb begin
    state_n     = state;
    z_ack_n     = 1'b0;
    rd_row_n    = rd_row;
    rd_col_n    = rd_col;
    written_n   = written;
    err_range_n = err_range_q;
    err_miss_n  = err_miss_q;
    we          = 1'b0;

    case (state)
      S_COLLECT: begin
        if (bus.z_stb && !z_ack_q) begin
          z_ack_n = 1'b1;
          if (in_range) begin
            we = 1'b1;
            written_n[wr_row][wr_col] = 1'b1;
          end else begin
            err_range_n = 1'b1;
          end
        end
        if (bus.done_in) begin
          err_miss_n = err_miss_q | (|(~written_n));
          rd_row_n   = '0;
          rd_col_n   = '0;
          state_n    = S_DRAIN;
        end
      end

      S_DRAIN: begin
        if (bus.out_ready) begin
          if (rd_col == LAST_IDX) begin
            rd_col_n = '0;
            if (rd_row == LAST_IDX) begin
              rd_row_n  = '0;
              written_n = '0;
              state_n   = S_COLLECT;
            end else begin
              rd_row_n = rd_row + 1'b1;
            end
          end else begin
            rd_col_n = rd_col + 1'b1;
          end
        end
      end

      default: state_n = S_COLLECT;
    endcase
  end

  // Stream outputs are gated so everything reads zero outside a drain,
  // including straight after reset when the buffer holds garbage.
  assign drain_active  = (state == S_DRAIN);
  assign bus.out_valid = drain_active;
  assign bus.busy      = drain_active;
  assign bus.out_data  = drain_active ? rd_data : '0;
  assign bus.out_row   = drain_active ? IW'(rd_row) : '0;
  assign bus.out_col   = drain_active ? IW'(rd_col) : '0;
  assign bus.out_last  = drain_active && (rd_row == LAST_IDX) && (rd_col == LAST_IDX);
  assign bus.z_ack     = z_ack_q;
  assign bus.err_range = err_range_q;
  assign bus.err_miss  = err_miss_q;

endmodule

// File: tb/tb_result_matrix_collector.sv
// Self-checking bench for result_matrix_collector with M=4.
// Purpose: stimulus pushes expected stream beats into a queue whenever a
//          drain is started; an independent monitor pops and compares on
//          every out_valid && out_ready transfer.
module tb_result_matrix_collector;

  localparam int M = 4;

  typedef struct {
    logic [4:0]  row;
    logic [4:0]  col;
    logic [31:0] data;
    logic        last;
    bit          chk;
  } beat_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  result_matrix_collector_if #(.IW(5), .DW(32)) bus ();

  result_matrix_collector #(.M(M), .IW(5), .DW(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  beat_t       exp_q[$];
  logic [31:0] model_val   [16];
  bit          model_known [16];
  int          n_vec = 0;
  int          n_err = 0;

  // IEEE-754 single encodings of 0.0 .. 15.0
  logic [31:0] flt_tab [16] = '{
    32'h00000000, 32'h3F800000, 32'h40000000, 32'h40400000,
    32'h40800000, 32'h40A00000, 32'h40C00000, 32'h40E00000,
    32'h41000000, 32'h41100000, 32'h41200000, 32'h41300000,
    32'h41400000, 32'h41500000, 32'h41600000, 32'h41700000
  };

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Queue the full row-major drain as predicted by the buffer model.
  // Entries not written since the previous drain are checked for position
  // and out_last only.
  task automatic pushDrain();
    beat_t b;
    for (int r = 0; r < M; r++) begin
      for (int c = 0; c < M; c++) begin
        b.row  = 5'(r);
        b.col  = 5'(c);
        b.data = model_val[r*M+c];
        b.last = (r == M-1) && (c == M-1);
        b.chk  = model_known[r*M+c];
        exp_q.push_back(b);
      end
    end
    for (int k = 0; k < 16; k++) model_known[k] = 1'b0;
  endtask

  // One result over z_stb/z_ack; optionally raise done_in in the same cycle.
  // Called and returns at #1 after a rising edge.
  task automatic applyStimulus(input logic [4:0] i, input logic [4:0] j,
                               input logic [31:0] val, input bit with_done);
    int waited;
    if (int'(i) < M && int'(j) < M) begin
      model_val[int'(i)*M+int'(j)]   = val;
      model_known[int'(i)*M+int'(j)] = 1'b1;
    end
    bus.z_i   = i;
    bus.z_j   = j;
    bus.z_in  = val;
    bus.z_stb = 1'b1;
    if (with_done) begin
      bus.done_in = 1'b1;
      pushDrain();
    end
    @(posedge clk); #1;
    bus.done_in = 1'b0;
    waited = 1;
    while (!bus.z_ack && waited < 10) begin
      @(posedge clk); #1;
      waited++;
    end
    checkOutput("ack_latency", 32'(waited), 32'd1);
    if (with_done) checkOutput("done_to_valid", 32'(bus.out_valid), 32'd1);
    @(posedge clk); #1;
    checkOutput("ack_single_cycle", 32'(bus.z_ack), 32'd0);
    bus.z_stb = 1'b0;
  endtask

  task automatic writeAll(input bit use_flt, input logic [31:0] base);
    for (int r = 0; r < M; r++)
      for (int c = 0; c < M; c++)
        applyStimulus(5'(r), 5'(c), use_flt ? flt_tab[r*M+c] : (base | 32'(r*M+c)), 1'b0);
  endtask

  task automatic startDrain();
    bus.done_in = 1'b1;
    pushDrain();
    @(posedge clk); #1;
    bus.done_in = 1'b0;
    checkOutput("done_to_valid", 32'(bus.out_valid), 32'd1);
    checkOutput("busy_in_drain", 32'(bus.busy), 32'd1);
  endtask

  // Drive out_ready from a 4-entry repeating pattern until every queued beat
  // has been seen and the collector has left the drain, or the budget ends.
  task automatic waitDrain(input bit p0, input bit p1, input bit p2, input bit p3);
    bit pat [4];
    int k;
    pat[0] = p0; pat[1] = p1; pat[2] = p2; pat[3] = p3;
    k = 0;
    bus.out_ready = pat[0];
    while (k < 200) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0 && !bus.busy) break;
      k++;
      bus.out_ready = pat[k % 4];
    end
    checkOutput("drain_beats_left", 32'(exp_q.size()), 32'd0);
    checkOutput("valid_after_drain", 32'(bus.out_valid), 32'd0);
    checkOutput("busy_after_drain", 32'(bus.busy), 32'd0);
    exp_q.delete();
    bus.out_ready = 1'b1;
  endtask

  // Monitor: compares every transferred beat and checks held outputs
  // during stalls.
  logic        stall_prev = 1'b0;
  logic [31:0] prev_data;
  logic [4:0]  prev_row, prev_col;

  always @(negedge clk) begin
    beat_t b;
    if (!rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev && bus.out_valid) begin
        checkOutput("stall_data_stable", bus.out_data, prev_data);
        checkOutput("stall_row_stable", 32'(bus.out_row), 32'(prev_row));
        checkOutput("stall_col_stable", 32'(bus.out_col), 32'(prev_col));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_beat", 32'(exp_q.size()), 32'd1);
        end else begin
          b = exp_q.pop_front();
          checkOutput("beat_row", 32'(bus.out_row), 32'(b.row));
          checkOutput("beat_col", 32'(bus.out_col), 32'(b.col));
          checkOutput("beat_last", 32'(bus.out_last), 32'(b.last));
          if (b.chk) checkOutput("beat_data", bus.out_data, b.data);
        end
      end
      stall_prev = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
      prev_row   = bus.out_row;
      prev_col   = bus.out_col;
    end
  end

  initial begin
    for (int k = 0; k < 16; k++) begin
      model_val[k]   = 32'h0;
      model_known[k] = 1'b0;
    end
    rst           = 1'b0;
    bus.z_in      = '0;
    bus.z_i       = '0;
    bus.z_j       = '0;
    bus.z_stb     = 1'b0;
    bus.done_in   = 1'b0;
    bus.out_ready = 1'b1;

    // Reset state
    #2;
    checkOutput("rst_z_ack", 32'(bus.z_ack), 32'd0);
    checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("rst_err_range", 32'(bus.err_range), 32'd0);
    checkOutput("rst_err_miss", 32'(bus.err_miss), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;

    $display("[TB] test 1: single result handshake");
    applyStimulus(5'd1, 5'd2, 32'h3F800000, 1'b0);
    checkOutput("t1_busy", 32'(bus.busy), 32'd0);

    $display("[TB] test 2: full matrix, done with final write");
    for (int idx = 0; idx < 15; idx++)
      applyStimulus(5'(idx / M), 5'(idx % M), flt_tab[idx], 1'b0);
    applyStimulus(5'd3, 5'd3, flt_tab[15], 1'b1);
    waitDrain(1'b1, 1'b1, 1'b1, 1'b1);
    checkOutput("t2_err_miss", 32'(bus.err_miss), 32'd0);

    $display("[TB] test 3: drain with out_ready pattern 1,0,0,1");
    writeAll(1'b1, 32'h0);
    bus.out_ready = 1'b0;
    startDrain();
    waitDrain(1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("t3_err_miss", 32'(bus.err_miss), 32'd0);

    $display("[TB] test 4: overwrite (0,0), partial matrix");
    applyStimulus(5'd0, 5'd0, 32'h3F800000, 1'b0);
    applyStimulus(5'd0, 5'd0, 32'h40400000, 1'b0);
    applyStimulus(5'd0, 5'd0, 32'h40C00000, 1'b0);
    startDrain();
    waitDrain(1'b1, 1'b1, 1'b1, 1'b1);
    checkOutput("t4_err_miss", 32'(bus.err_miss), 32'd1);

    $display("[TB] test 5: out-of-range index and strobe during drain");
    writeAll(1'b0, 32'hA5000000);
    checkOutput("t5_err_range_before", 32'(bus.err_range), 32'd0);
    applyStimulus(5'd4, 5'd0, 32'hDEADBEEF, 1'b0);
    checkOutput("t5_err_range", 32'(bus.err_range), 32'd1);
    applyStimulus(5'd1, 5'd7, 32'hCAFEF00D, 1'b0);
    bus.out_ready = 1'b0;
    startDrain();
    bus.z_i   = 5'd2;
    bus.z_j   = 5'd2;
    bus.z_in  = 32'h12345678;
    bus.z_stb = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      checkOutput("t5_no_ack_in_drain", 32'(bus.z_ack), 32'd0);
    end
    waitDrain(1'b1, 1'b1, 1'b1, 1'b1);
    begin
      int waited;
      waited = 0;
      while (!bus.z_ack && waited < 5) begin
        @(posedge clk); #1;
        waited++;
      end
      checkOutput("t5_ack_after_drain", 32'(waited), 32'd1);
    end
    @(posedge clk); #1;
    checkOutput("t5_ack_single_cycle", 32'(bus.z_ack), 32'd0);
    bus.z_stb = 1'b0;
    checkOutput("t5_err_range_sticky", 32'(bus.err_range), 32'd1);

    $display("[TB] test 6: reset mid-drain, then full drain");
    writeAll(1'b1, 32'h0);
    bus.out_ready = 1'b1;
    startDrain();
    repeat (7) begin
      @(posedge clk); #1;
    end
    checkOutput("t6_beats_before_reset", 32'(exp_q.size()), 32'd9);
    rst = 1'b0;
    #1;
    checkOutput("t6_rst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("t6_rst_out_data", bus.out_data, 32'd0);
    checkOutput("t6_rst_out_row", 32'(bus.out_row), 32'd0);
    checkOutput("t6_rst_out_col", 32'(bus.out_col), 32'd0);
    checkOutput("t6_rst_out_last", 32'(bus.out_last), 32'd0);
    checkOutput("t6_rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("t6_rst_err_range", 32'(bus.err_range), 32'd0);
    checkOutput("t6_rst_err_miss", 32'(bus.err_miss), 32'd0);
    exp_q.delete();
    for (int k = 0; k < 16; k++) model_known[k] = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    writeAll(1'b1, 32'h0);
    startDrain();
    waitDrain(1'b1, 1'b1, 1'b1, 1'b1);
    checkOutput("t6_err_miss", 32'(bus.err_miss), 32'd0);
    checkOutput("t6_err_range", 32'(bus.err_range), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
